inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Write-side counterpart of the instruction memory read port: takes a byte stream from the serial receiver, assembles big-endian 32-bit instructions, and writes them into the instruction BRAM write port (addra/dina/wea).
- After the declared program length has been written, pulses loader_ready for exactly one cycle so the core can release PC from reset.
- Sits between the UART receiver and the instruction memory.

Parameters:
INST_MEM_WIDTH, 5, address width of instruction memory; capacity = 2^INST_MEM_WIDTH words

Ports:
CLK  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  arm the loader; sampled only in IDLE
rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
rx_data  input  8  received byte
wr_en  output  1  write strobe to instruction memory (wea)
wr_addr  output  INST_MEM_WIDTH  write word address (addra)
wr_data  output  32  write data (dina)
loading  output  1  high from HEADER through end of CHECK
loader_ready  output  1  one-cycle pulse: load complete
overflow  output  1  sticky; declared length exceeded capacity
chk_err  output  1  sticky; checksum mismatch (only with feature enabled)

Behaviour:
- Reset: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, loading=0, loader_ready=0, overflow=0, chk_err=0; byte counter, word counter, length, shift register all 0. Reset mid-load aborts immediately. No further writes occur after reset.
- Byte assembly: 2-bit byte counter. Each accepted byte shifts into a 32-bit shift register as {sr[23:0], rx_data}, so the first byte becomes bits [31:24]. A word is complete on the 4th byte.
- States:
  - IDLE: rx_valid ignored. start=1 -> HEADER; loading=1 from the next cycle; overflow and chk_err cleared.
  - HEADER: collect 4 bytes -> 32-bit length N.
    - N==0 -> DONE (with feature: -> CHECK).
    - N>0 -> LOAD; word counter=0.
    - N > 2^INST_MEM_WIDTH -> overflow=1 at the same time.
  - LOAD: on each completed word:
    - Next cycle: wr_en=1 for exactly one cycle, wr_addr=word index (low INST_MEM_WIDTH bits), wr_data=assembled word.
    - Word counter increments.
    - Words with index >= 2^INST_MEM_WIDTH are consumed but not written (wr_en stays 0), so wrap-around never overwrites address 0.
    - When counter reaches N -> DONE (with feature: -> CHECK).
  - DONE: one cycle. loader_ready=1, loading=0 -> IDLE. loader_ready is never held high for more than one cycle.
- Latency: last byte of the last word -> wr_en in cycle +1 -> loader_ready in cycle +2.
- Simultaneous events:
  - start while not in IDLE is ignored.
  - start in the same cycle as a loader_ready pulse is ignored; start is re-sampled in IDLE on the following cycle.
  - rx_valid on consecutive cycles must be handled: one byte per cycle, no byte loss.
- Counters: word counter and length are 32-bit; the comparison uses the full width.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 32-bit XOR of all payload words (including words that are not written) is accumulated.
  - After the N-th word, state CHECK collects 4 more bytes as the expected checksum (big-endian).
  - Mismatch -> chk_err=1 (sticky until next start). Match -> chk_err=0.
  - Either way -> DONE; loader_ready still pulses once.
- Not defined: no CHECK state; LOAD -> DONE directly; chk_err tied to 0.

Test Plan:
- Basic load, INST_MEM_WIDTH=5: start; bytes 00 00 00 02, 12 34 56 78, 08 00 00 00 -> wr_en pulses at addr 0 data 0x12345678 and addr 1 data 0x08000000; loader_ready one cycle, 2 cycles after the last byte; overflow=0.
- Zero length: start; 00 00 00 00 -> no wr_en; loader_ready pulses once; loading back to 0.
- Overflow, W=5: header N=33, 33 words where word i = i -> addrs 0..31 written, 33rd word not written (addr 0 still holds 0); overflow=1; loader_ready pulses once.
- Back-to-back bytes plus ignored inputs: bytes fed on consecutive cycles give correct words; rx_valid in IDLE and a start pulse during LOAD change nothing.
- Reset mid-load: reset asserted after 2 of 4 words -> all outputs 0, state IDLE, no further wr_en. A fresh start then loads correctly from addr 0.
- LOADER_CHECKSUM_EN: N=2, words 0x0F0F0000 and 0x00000F0F.
  - Checksum 0F 0F 0F 0F -> chk_err=0.
  - Checksum 00 00 00 01 -> chk_err=1.
  - loader_ready pulses once in both cases.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: assembles a big-endian byte stream from the serial receiver
// into 32-bit instructions and writes them into the instruction BRAM write
// port. The stream is a 32-bit word count N followed by N instruction words.
// loader_ready pulses once when the whole program has been written.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum word after payload).
module inst_loader #(
  parameter int INST_MEM_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      wr_en,
  output logic [INST_MEM_WIDTH-1:0] wr_addr,
  output logic [31:0]               wr_data,
  output logic                      loading,
  output logic                      loader_ready,
  output logic                      overflow,
  output logic                      chk_err
);

  localparam logic [31:0] CAPACITY = 32'd1 << INST_MEM_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  // Only the three most recent bytes need storing; the fourth byte of a word
  // arrives on rx_data and completes the word combinationally.
  logic [23:0]               sr_q, sr_d;
  logic [31:0]               len_q, len_d;
  logic [31:0]               word_cnt_q, word_cnt_d;
  logic                      wr_en_q, wr_en_d;
  logic [INST_MEM_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]               wr_data_q, wr_data_d;
  logic                      overflow_q, overflow_d;
  logic                      chk_err_q, chk_err_d;
  logic [31:0]               csum_q, csum_d;

  logic [31:0] word_full;
  logic        word_done;

  assign word_full = {sr_q, rx_data};
  assign word_done = rx_valid && (byte_cnt_q == 2'd3);

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    overflow_d = overflow_q;
    chk_err_d  = chk_err_q;
    csum_d     = csum_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HEADER;
          byte_cnt_d = 2'd0;
          overflow_d = 1'b0;
          chk_err_d  = 1'b0;
          csum_d     = 32'd0;
        end
      end

      HEADER: begin
        if (rx_valid) begin
          sr_d       = word_full[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_done) begin
            len_d      = word_full;
            word_cnt_d = 32'd0;
            overflow_d = (word_full > CAPACITY);
            if (word_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end else begin
              state_d = LOAD;
            end
          end
        end
      end

      LOAD: begin
`ifndef LOADER_CHECKSUM_EN
        // Finishing on the cycle after the last write keeps loader_ready one
        // cycle behind wr_en; no further payload bytes are expected here.
        if (word_cnt_q == len_q) begin
          state_d = DONE;
        end else
`endif
        if (rx_valid) begin
          sr_d       = word_full[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_done) begin
            // Words beyond capacity are swallowed so address 0 is never
            // overwritten by wrap-around.
            wr_en_d    = (word_cnt_q < CAPACITY);
            wr_addr_d  = word_cnt_q[INST_MEM_WIDTH-1:0];
            wr_data_d  = word_full;
            word_cnt_d = word_cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ word_full;
            // Move on immediately so a checksum byte on the next cycle is kept.
            if (word_cnt_q + 32'd1 == len_q) begin
              state_d = CHECK;
            end
`endif
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          sr_d       = word_full[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_done) begin
            chk_err_d = (word_full != csum_q);
            state_d   = DONE;
          end
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      sr_q       <= 24'd0;
      len_q      <= 32'd0;
      word_cnt_q <= 32'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
      overflow_q <= 1'b0;
      chk_err_q  <= 1'b0;
      csum_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
      chk_err_q  <= chk_err_d;
      csum_q     <= csum_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign overflow     = overflow_q;
  assign loading      = (state_q == HEADER) || (state_q == LOAD) || (state_q == CHECK);
  assign loader_ready = (state_q == DONE);
`ifdef LOADER_CHECKSUM_EN
  assign chk_err      = chk_err_q;
`else
  assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader (INST_MEM_WIDTH = 5).
module tb_inst_loader;

  localparam int W = 5;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic [31:0]  wr_data;
  logic         loading;
  logic         loader_ready;
  logic         overflow;
  logic         chk_err;

  inst_loader #(.INST_MEM_WIDTH(W)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .loading      (loading),
    .loader_ready (loader_ready),
    .overflow     (overflow),
    .chk_err      (chk_err)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rdy_cnt = 0;
  int          last_wr_cyc = -1;
  int          rdy_cyc = -1;
  int          last_byte_cyc = -1;
  logic [31:0] mem [0:(1<<W)-1];
  logic [31:0] xsum;

  always @(posedge CLK) cyc <= cyc + 1;

  // Mid-cycle monitor: a shadow of the instruction memory plus pulse counts.
  always @(negedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      wr_cnt       = wr_cnt + 1;
      last_wr_cyc  = cyc;
      $display("write addr=%0d data=%08h", wr_addr, wr_data);
    end
    if (loader_ready) begin
      rdy_cnt = rdy_cnt + 1;
      rdy_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < (1 << W); i++) mem[i] = 32'hDEAD_BEEF;
    wr_cnt      = 0;
    rdy_cnt     = 0;
    last_wr_cyc = -1;
    rdy_cyc     = -1;
    xsum        = 32'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK);
    #1;
    last_byte_cyc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_payload(input logic [31:0] w);
    xsum = xsum ^ w;
    send_word(w);
  endtask

  // Sends the trailing checksum only when the feature is built in.
  task automatic finish_prog();
`ifdef LOADER_CHECKSUM_EN
    send_word(xsum);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clear_log();
    idle(3);
    check("rst_wr_en",    {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr",  {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data",  wr_data, 32'd0);
    check("rst_loading",  {31'd0, loading}, 32'd0);
    check("rst_ready",    {31'd0, loader_ready}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_chk_err",  {31'd0, chk_err}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Basic two-word load.
    clear_log();
    pulse_start();
    check("basic_loading", {31'd0, loading}, 32'd1);
    send_word(32'd2);
    send_payload(32'h1234_5678);
    send_payload(32'h0800_0000);
`ifndef LOADER_CHECKSUM_EN
    begin
      int k;
      k = last_byte_cyc;
      idle(5);
      check("basic_wr_lat",  last_wr_cyc, k);
      check("basic_rdy_lat", rdy_cyc, k + 1);
    end
`else
    finish_prog();
    idle(5);
`endif
    check("basic_wr_cnt",   wr_cnt, 2);
    check("basic_mem0",     mem[0], 32'h1234_5678);
    check("basic_mem1",     mem[1], 32'h0800_0000);
    check("basic_rdy_cnt",  rdy_cnt, 1);
    check("basic_overflow", {31'd0, overflow}, 32'd0);
    check("basic_loading_end", {31'd0, loading}, 32'd0);

    // Zero-length program.
    clear_log();
    pulse_start();
    send_word(32'd0);
    finish_prog();
    idle(5);
    check("zero_wr_cnt",  wr_cnt, 0);
    check("zero_rdy_cnt", rdy_cnt, 1);
    check("zero_loading", {31'd0, loading}, 32'd0);

    // Overflow: 33 words into a 32-word memory.
    clear_log();
    pulse_start();
    send_word(32'd33);
    idle(1);
    check("ovf_flag_early", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 33; i++) send_payload(i);
    finish_prog();
    idle(5);
    check("ovf_wr_cnt",  wr_cnt, 32);
    check("ovf_mem0",    mem[0], 32'd0);
    check("ovf_mem31",   mem[31], 32'd31);
    check("ovf_flag",    {31'd0, overflow}, 32'd1);
    check("ovf_rdy_cnt", rdy_cnt, 1);

    // Bytes in IDLE are ignored; start during LOAD is ignored.
    clear_log();
    send_word(32'hFFFF_FFFF);
    idle(3);
    check("idle_rx_wr_cnt",  wr_cnt, 0);
    check("idle_rx_loading", {31'd0, loading}, 32'd0);
    pulse_start();
    send_word(32'd3);
    send_payload(32'hAABB_CCDD);
    pulse_start();
    send_payload(32'h0102_0304);
    send_payload(32'hCAFE_BABE);
    finish_prog();
    idle(5);
    check("b2b_wr_cnt",  wr_cnt, 3);
    check("b2b_mem0",    mem[0], 32'hAABB_CCDD);
    check("b2b_mem1",    mem[1], 32'h0102_0304);
    check("b2b_mem2",    mem[2], 32'hCAFE_BABE);
    check("b2b_rdy_cnt", rdy_cnt, 1);
    check("b2b_overflow_clr", {31'd0, overflow}, 32'd0);

    // Reset after 2 of 4 words aborts the load.
    clear_log();
    pulse_start();
    send_word(32'd4);
    send_payload(32'h1111_1111);
    send_payload(32'h2222_2222);
    reset = 1'b1;
    idle(1);
    check("mid_rst_wr_en",   {31'd0, wr_en}, 32'd0);
    check("mid_rst_addr",    {27'd0, wr_addr}, 32'd0);
    check("mid_rst_data",    wr_data, 32'd0);
    check("mid_rst_loading", {31'd0, loading}, 32'd0);
    reset = 1'b0;
    clear_log();
    send_word(32'h3333_3333);
    send_word(32'h4444_4444);
    idle(4);
    check("mid_rst_no_wr",  wr_cnt, 0);
    check("mid_rst_no_rdy", rdy_cnt, 0);
    pulse_start();
    send_word(32'd1);
    send_payload(32'h5566_7788);
    finish_prog();
    idle(5);
    check("reload_wr_cnt",  wr_cnt, 1);
    check("reload_mem0",    mem[0], 32'h5566_7788);
    check("reload_rdy_cnt", rdy_cnt, 1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    clear_log();
    pulse_start();
    send_word(32'd2);
    send_payload(32'h0F0F_0000);
    send_payload(32'h0000_0F0F);
    send_word(32'h0F0F_0F0F);
    idle(5);
    check("csum_ok_err", {31'd0, chk_err}, 32'd0);
    check("csum_ok_rdy", rdy_cnt, 1);
    clear_log();
    pulse_start();
    send_word(32'd2);
    send_payload(32'h0F0F_0000);
    send_payload(32'h0000_0F0F);
    send_word(32'h0000_0001);
    idle(5);
    check("csum_bad_err", {31'd0, chk_err}, 32'd1);
    check("csum_bad_rdy", rdy_cnt, 1);
`else
    check("chk_err_tied", {31'd0, chk_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
